// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 256;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_rx_state_e;

  // Expected parity bit for a data byte; odd = 1 selects odd parity.
  function automatic logic uart_parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                           input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_bps_gen.sv
// Enable-gated bit-phase counter; ticks once per bit at the bit centre.
module uart_rx_bps_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic bps_en,
  output logic bps_tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);

  if ((CLKS_PER_BIT % 2) != 0 || CLKS_PER_BIT < 8) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be even and at least 8");
  end

  logic [CntW-1:0] r_cnt;

  // Phase counter: held at zero while disabled so each frame restarts the phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!bps_en) begin
      r_cnt <= '0;
    end else if (r_cnt == CntLast) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bps_tick = bps_en & (r_cnt == CntHalf);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 8N1 frames, or 8E1/8O1 when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      frame_err,
  output logic                      parity_err,
  output logic                      busy
);

  localparam logic [2:0] LastIdx = 3'(UART_DATA_BITS - 1);

  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("PARITY_ODD must be 0 or 1");
  end

  logic                      r_sync1, r_rx_s, r_rx_prev;
  logic                      w_fall, w_tick, w_bps_en;
  uart_rx_state_e            r_state, w_state_d;
  logic [2:0]                r_idx, w_idx_d;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_d;
  logic [UART_DATA_BITS-1:0] r_data, w_data_d;
  logic                      r_valid, w_valid_d;
  logic                      r_ferr, w_ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                      r_par_mis, w_par_mis_d;
  logic                      r_perr, w_perr_d;
`endif

  // Two-flop synchronizer plus previous-value flop for falling-edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_fall   = r_rx_prev & ~r_rx_s;
  assign w_bps_en = (r_state != StIdle);

  uart_rx_bps_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bps_gen (
    .clk     (clk),
    .reset   (reset),
    .bps_en  (w_bps_en),
    .bps_tick(w_tick)
  );

  // Frame sequencer: next state, shift/index updates and output pulse requests.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_shift_d = r_shift;
    w_data_d  = r_data;
    w_valid_d = 1'b0;
    w_ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_mis_d = r_par_mis;
    w_perr_d    = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_fall) begin
          w_state_d = StStart;
`ifdef UART_RX_PARITY_EN
          w_par_mis_d = 1'b0;
`endif
        end
      end
      StStart: begin
        if (w_tick) begin
          w_idx_d   = '0;
          w_state_d = r_rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (w_tick) begin
          // LSB arrives first, so shifting in at the MSB leaves the byte aligned.
          w_shift_d = {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
          w_idx_d   = r_idx + 1'b1;
          if (r_idx == LastIdx) begin
`ifdef UART_RX_PARITY_EN
            w_state_d = StParity;
`else
            w_state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (w_tick) begin
          w_par_mis_d = r_rx_s != uart_parity_bit(r_shift, 1'(PARITY_ODD));
          w_state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (w_tick) begin
          w_state_d = StIdle;
          if (!r_rx_s) begin
            w_ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (r_par_mis) begin
            w_perr_d = 1'b1;
`endif
          end else begin
            w_valid_d = 1'b1;
            w_data_d  = r_shift;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_mis <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_shift <= w_shift_d;
      r_data  <= w_data_d;
      r_valid <= w_valid_d;
      r_ferr  <= w_ferr_d;
`ifdef UART_RX_PARITY_EN
      r_par_mis <= w_par_mis_d;
      r_perr    <= w_perr_d;
`endif
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences an enable-gated baud tick generator to capture 8N1 frames (optionally 8E1/8O1) from the asynchronous `rx` line. It sits between the board-level RX pin and the byte consumer, detects start bits, restarts the bit-centre sampling phase on each frame, and delivers one byte per frame with a single-cycle valid strobe. The default configuration targets 2.4576 MHz clk at 9600 baud.

## Interface
- `CLKS_PER_BIT`, default 256: clk cycles per bit; even, at least 8.
- `PARITY_ODD`, default 0: parity sense when parity is compiled in; 0 = even, 1 = odd.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  raw serial line, idle high, asynchronous to clk.
- `rx_data`  out  8  last good byte; holds its value until the next good frame.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `parity_err`  out  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- A falling-edge detect flop (`rx_s` was 1, is now 0) arms the frame. It also resets to 1.
- The baud sub-module runs only while `bps_en` is high:
  - The phase counter is 0 while disabled.
  - It counts 0..`CLKS_PER_BIT`-1 and wraps.
  - `bps_tick` fires combinationally when counter == `CLKS_PER_BIT`/2, which is mid-bit.
- States are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `bps_en` = 0.
  - A falling edge moves to START and sets `bps_en` = 1 from the next cycle.
- START:
  - On tick, `rx_s` = 0 moves to DATA, with bit index 0.
  - On tick, `rx_s` = 1 is a false start: return to IDLE with no output pulse.
- DATA:
  - Each tick shifts `rx_s` into the MSB of the shift register (LSB-first on the wire).
  - After the 8th tick (index 7), move to PARITY if compiled in, otherwise to STOP.
- PARITY: on tick, compare `rx_s` against the computed parity bit, latch the mismatch flag, then move to STOP.
- STOP, on tick:
  - `rx_s` = 1 with no parity mismatch: load `rx_data`, pulse `rx_valid`.
  - `rx_s` = 1 with a parity mismatch: pulse `parity_err`; `rx_data` is unchanged.
  - `rx_s` = 0: pulse `frame_err`; `rx_data` is unchanged; `parity_err` is suppressed.
  - In every case return to IDLE.
- A line stuck low after a frame error does not retrigger, because a new edge needs `rx_s` to return high first.
- Reset mid-frame: all state is cleared asynchronously and the partial byte is discarded. Recovery needs a fresh falling edge.

## Timing
- Reset values:
  - `rx_data` = 0x00.
  - `rx_valid`, `frame_err`, `parity_err`, `busy` = 0.
  - State = IDLE.
- Edge-detect latency: 2 synchronizer cycles plus 1 detect cycle from `rx` falling to the START transition.
- Sampling point: (`CLKS_PER_BIT`/2 + 1) cycles after START entry, then every `CLKS_PER_BIT` cycles.
- Output pulses are registered. They are high exactly one cycle, in the cycle after the stop-bit tick.
- IDLE is re-entered in the same cycle as the output pulse. A start edge on the following cycle is accepted, so back-to-back frames are supported.
- `busy` is high from the cycle after edge detection through the stop-bit tick.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the PARITY state exists, a 9th data-phase tick samples the parity bit, and `parity_err` is live.
  - Undefined: the frame is 8N1, PARITY is unreachable and not synthesized, `parity_err` is tied 0, and `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg`:
  - State encoding constants: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4, in 3 bits.
  - `UART_DATA_BITS` = 8.
  - Default `CLKS_PER_BIT` = 256.
- Sub-module `uart_rx_bps_gen`:
  - Ports `clk`, `reset`, `bps_en`, `bps_tick`.
  - Parameter `CLKS_PER_BIT`.
  - Counter width is log2(`CLKS_PER_BIT`).
  - Counter clears synchronously when `bps_en` = 0.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.
- Send 0xA5 as 8N1 → exactly one `rx_valid` pulse, `rx_data` = 0xA5, no error pulses, `busy` low afterwards.
- 3-cycle low glitch on an idle line → false start. No pulses; `busy` returns low 10 cycles after the glitch.
- Send 0x3C with a low stop bit, line then held low for 50 cycles → one `frame_err` pulse, `rx_data` keeps its prior value, no retrigger until the line goes high and falls again.
- Send 0x00 then 0xFF back-to-back with zero idle gap → two `rx_valid` pulses with data 0x00, then 0xFF.
- Assert `reset` low during DATA bit 4 of 0x5A, release, then send 0x81 → no output for 0x5A; 0x81 received cleanly.
- With `UART_RX_PARITY_EN` and `PARITY_ODD` = 0: send 0x07 with parity bit 1 → valid, 0x07. Send 0x07 with parity bit 0 → `parity_err` pulse, `rx_data` unchanged.
